// File: rtl/ice_uart.sv
// ice_uart
// Byte-oriented full-duplex 8N1 UART (LSB first, idle-high line) with a
// runtime-programmable baud divisor. The transmitter and receiver are
// independent machines sharing only the clock, reset and divisor.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   reset     asynchronous active-high reset, clears all state
//   baud_div  clk cycles per bit period (0 and 1 behave as 2), stable while busy
//   rx_in     serial receive line (asynchronous, idle high)
//   tx_out    serial transmit line (idle high)
//   tx_latch  one-cycle strobe: load tx_data and start a frame when tx_empty=1
//   tx_data   byte to transmit, sampled only on the accepting edge
//   tx_empty  transmitter idle and able to accept a byte
//   rx_data   last correctly received byte
//   rx_latch  one-cycle pulse when rx_data is updated
//   rx_error  one-cycle pulse on a framing error (stop bit sampled low)
module ice_uart (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] baud_div,
    input  logic        rx_in,
    output logic        tx_out,
    input  logic        tx_latch,
    input  logic [7:0]  tx_data,
    output logic        tx_empty,
    output logic [7:0]  rx_data,
    output logic        rx_latch,
    output logic        rx_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

    // Divisors below 2 would leave no room for a mid-bit sample point.
    logic [15:0] div_eff;
    logic [15:0] div_last;
    logic [15:0] half_last;

    assign div_eff   = (baud_div < 16'd2) ? 16'd2 : baud_div;
    assign div_last  = div_eff - 16'd1;
    assign half_last = {1'b0, div_eff[15:1]} - 16'd1;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_t tx_state_reg, tx_state_next;
    logic [15:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]  tx_bit_reg, tx_bit_next;
    logic [7:0]  tx_shift_reg, tx_shift_next;
    logic        tx_out_reg, tx_out_next;
    logic        tx_empty_reg, tx_empty_next;
    logic        tx_bit_end;

    assign tx_bit_end = (tx_cnt_reg == div_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_reg <= S_IDLE;
            tx_cnt_reg   <= 16'd0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'h00;
            tx_out_reg   <= 1'b1;
            tx_empty_reg <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_out_reg   <= tx_out_next;
            tx_empty_reg <= tx_empty_next;
        end
    end

    // tx_out and tx_empty are registered so the line changes exactly on the
    // accepting edge and on every bit boundary after it. Accepting on the
    // registered tx_empty means a strobe on the edge where tx_empty rises
    // is not yet seen as idle.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_out_next   = tx_out_reg;
        tx_empty_next = tx_empty_reg;
        case (tx_state_reg)
            S_IDLE: begin
                if (tx_latch && tx_empty_reg) begin
                    tx_state_next = S_START;
                    tx_cnt_next   = 16'd0;
                    tx_shift_next = tx_data;
                    tx_out_next   = 1'b0;
                    tx_empty_next = 1'b0;
                end
            end
            S_START: begin
                if (tx_bit_end) begin
                    tx_state_next = S_DATA;
                    tx_cnt_next   = 16'd0;
                    tx_bit_next   = 3'd0;
                    tx_out_next   = tx_shift_reg[0];
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                end else begin
                    tx_cnt_next = tx_cnt_reg + 16'd1;
                end
            end
            S_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_next = 16'd0;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = S_STOP;
                        tx_out_next   = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        tx_out_next   = tx_shift_reg[0];
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 16'd1;
                end
            end
            S_STOP: begin
                if (tx_bit_end) begin
                    tx_state_next = S_IDLE;
                    tx_cnt_next   = 16'd0;
                    tx_out_next   = 1'b1;
                    tx_empty_next = 1'b1;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 16'd1;
                end
            end
            default: begin
                tx_state_next = S_IDLE;
                tx_out_next   = 1'b1;
                tx_empty_next = 1'b1;
            end
        endcase
    end

    assign tx_out   = tx_out_reg;
    assign tx_empty = tx_empty_reg;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    // Synchroniser and edge-detect flops reset high (idle line) so that
    // leaving reset never looks like a start bit.
    logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx_in;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    uart_state_t rx_state_reg, rx_state_next;
    logic [15:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]  rx_bit_reg, rx_bit_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic [7:0]  rx_data_reg, rx_data_next;
    logic        rx_latch_reg, rx_latch_next;
    logic        rx_error_reg, rx_error_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_reg <= S_IDLE;
            rx_cnt_reg   <= 16'd0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'h00;
            rx_data_reg  <= 8'h00;
            rx_latch_reg <= 1'b0;
            rx_error_reg <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            rx_latch_reg <= rx_latch_next;
            rx_error_reg <= rx_error_next;
        end
    end

    // A start is armed only by a high-to-low transition of the synchronised
    // line, so after a framing error the line has to go high again before
    // another frame can begin. The START wait of half a bit moves every later
    // sample to mid-bit.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        rx_latch_next = 1'b0;
        rx_error_next = 1'b0;
        case (rx_state_reg)
            S_IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_state_next = S_START;
                    rx_cnt_next   = 16'd0;
                end
            end
            S_START: begin
                if (rx_cnt_reg == half_last) begin
                    rx_cnt_next = 16'd0;
                    if (rx_sync_reg) begin
                        // Line back high at mid start bit: glitch.
                        rx_state_next = S_IDLE;
                    end else begin
                        rx_state_next = S_DATA;
                        rx_bit_next   = 3'd0;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_reg == div_last) begin
                    rx_cnt_next   = 16'd0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    if (rx_bit_reg == 3'd7) begin
                        rx_state_next = S_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 3'd1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt_reg == div_last) begin
                    rx_cnt_next   = 16'd0;
                    rx_state_next = S_IDLE;
                    if (rx_sync_reg) begin
                        rx_data_next  = rx_shift_reg;
                        rx_latch_next = 1'b1;
                    end else begin
                        rx_error_next = 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 16'd1;
                end
            end
            default: begin
                rx_state_next = S_IDLE;
            end
        endcase
    end

    assign rx_data  = rx_data_reg;
    assign rx_latch = rx_latch_reg;
    assign rx_error = rx_error_reg;

endmodule

// File: tb/tb_ice_uart.sv
// Directed testbench for ice_uart: reset abort, TX framing and timing,
// ignored strobe, loopback streaming, RX framing error, RX glitch rejection
// and the minimum-divisor clamp.
module tb_ice_uart;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] baud_div = 16'd174;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rx_line;
    logic        tx_out;
    logic        tx_latch = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_empty;
    logic [7:0]  rx_data;
    logic        rx_latch;
    logic        rx_error;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign rx_line = loop_en ? tx_out : rx_drv;

    ice_uart dut (
        .clk      (clk),
        .reset    (reset),
        .baud_div (baud_div),
        .rx_in    (rx_line),
        .tx_out   (tx_out),
        .tx_latch (tx_latch),
        .tx_data  (tx_data),
        .tx_empty (tx_empty),
        .rx_data  (rx_data),
        .rx_latch (rx_latch),
        .rx_error (rx_error)
    );

    // Free-running cycle counter and receive-side event log.
    int         cyc = 0;
    logic [7:0] rx_log [0:15];
    int         rx_log_n = 0;
    int         err_n = 0;
    int         last_latch_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_latch === 1'b1) begin
            if (rx_log_n < 16) rx_log[rx_log_n[3:0]] <= rx_data;
            rx_log_n       <= rx_log_n + 1;
            last_latch_cyc <= cyc;
            $display("rx_latch: data=%h at cycle %0d", rx_data, cyc);
        end
        if (rx_error === 1'b1) begin
            err_n <= err_n + 1;
            $display("rx_error at cycle %0d", cyc);
        end
    end

    // Strobes d at the current negedge and checks every cycle of the frame
    // plus the tx_empty low time. Returns on the negedge where tx_empty must
    // be high again, so a following call strobes at the earliest legal edge.
    task automatic tx_frame_check(input logic [7:0] d, input int div,
                                  input bit junk, input string tag);
        logic [9:0] frame;
        int bad;
        int empty_low;
        frame = {1'b1, d, 1'b0};
        tx_data  = d;
        tx_latch = 1'b1;
        @(negedge clk);
        tx_latch = 1'b0;
        tx_data  = 8'h00;
        empty_low = 0;
        for (int i = 0; i < 10; i++) begin
            bad = 0;
            for (int c = 0; c < div; c++) begin
                if (tx_out !== frame[i]) bad++;
                if (tx_empty === 1'b0) empty_low++;
                if (junk && i == 4) tx_latch = (c == 10);
                @(negedge clk);
            end
            total_cnt++;
            if (bad == 0) pass_cnt++;
            else $display("FAIL %s bit%0d: %0d cycles differ from required level %b", tag, i, bad, frame[i]);
        end
        total_cnt++;
        if (tx_empty === 1'b1 && empty_low == 10 * div) pass_cnt++;
        else $display("FAIL %s tx_empty: low %0d cycles (now %b), required %0d then 1", tag, empty_low, tx_empty, 10 * div);
        $display("tx frame %s byte=%h done at cycle %0d", tag, d, cyc);
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop, input int div);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            repeat (div) @(negedge clk);
        end
        rx_drv = 1'b1;
        $display("rx frame driven byte=%h stop=%b at cycle %0d", d, stop, cyc);
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (tx_out === 1'b1) pass_cnt++; else $display("FAIL reset tx_out: got %b need 1", tx_out);
        total_cnt++; if (tx_empty === 1'b1) pass_cnt++; else $display("FAIL reset tx_empty: got %b need 1", tx_empty);
        total_cnt++; if (rx_data === 8'h00) pass_cnt++; else $display("FAIL reset rx_data: got %h need 00", rx_data);
        total_cnt++; if (rx_latch === 1'b0) pass_cnt++; else $display("FAIL reset rx_latch: got %b need 0", rx_latch);
        total_cnt++; if (rx_error === 1'b0) pass_cnt++; else $display("FAIL reset rx_error: got %b need 0", rx_error);
        reset = 1'b0;
        @(negedge clk);
        // Start a frame of 0x00 and abort it a little past three bit periods.
        tx_data  = 8'h00;
        tx_latch = 1'b1;
        @(negedge clk);
        tx_latch = 1'b0;
        repeat (3 * 174 + 20) @(negedge clk);
        total_cnt++; if (tx_out === 1'b0 && tx_empty === 1'b0) pass_cnt++;
        else $display("FAIL midframe: tx_out=%b tx_empty=%b need 0/0", tx_out, tx_empty);
        reset = 1'b1;
        #1;
        total_cnt++; if (tx_out === 1'b1 && tx_empty === 1'b1) pass_cnt++;
        else $display("FAIL async reset: tx_out=%b tx_empty=%b need 1/1", tx_out, tx_empty);
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (4 * 174) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || tx_empty !== 1'b1) bad++;
        end
        total_cnt++; if (bad == 0) pass_cnt++; else $display("FAIL post-reset idle: %0d bad cycles, need 0", bad);
        total_cnt++; if (rx_log_n == 0 && err_n == 0) pass_cnt++;
        else $display("FAIL post-reset rx: latches=%0d errors=%0d need 0/0", rx_log_n, err_n);
        $display("test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_tx_a5();
        tx_frame_check(8'hA5, 174, 1'b0, "tx_a5");
    endtask

    task automatic test_ignored_strobe();
        int bad;
        tx_frame_check(8'hFF, 174, 1'b1, "tx_ff_junk");
        bad = 0;
        repeat (3 * 174) begin
            if (tx_out !== 1'b1 || tx_empty !== 1'b1) bad++;
            @(negedge clk);
        end
        total_cnt++; if (bad == 0) pass_cnt++; else $display("FAIL no second frame: %0d busy cycles, need 0", bad);
    endtask

    task automatic test_back_to_back();
        int n0;
        int e0;
        logic [7:0] exp_bytes [0:2];
        exp_bytes[0] = 8'h00;
        exp_bytes[1] = 8'h55;
        exp_bytes[2] = 8'hFF;
        n0 = rx_log_n;
        e0 = err_n;
        loop_en = 1'b1;
        for (int k = 0; k < 3; k++) tx_frame_check(exp_bytes[k], 174, 1'b0, "loop");
        repeat (20) @(negedge clk);
        loop_en = 1'b0;
        total_cnt++; if (rx_log_n - n0 == 3) pass_cnt++; else $display("FAIL loop latch count: got %0d need 3", rx_log_n - n0);
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = n0 + k;
            total_cnt++;
            if (rx_log[idx[3:0]] === exp_bytes[k]) pass_cnt++;
            else $display("FAIL loop byte%0d: got %h need %h", k, rx_log[idx[3:0]], exp_bytes[k]);
        end
        total_cnt++; if (err_n == e0) pass_cnt++; else $display("FAIL loop rx_error: got %0d pulses need 0", err_n - e0);
    endtask

    task automatic test_framing_error();
        int n0;
        int e0;
        int t0;
        int lat;
        n0 = rx_log_n;
        e0 = err_n;
        drive_rx(8'h3C, 1'b0, 174);
        repeat (2 * 174) @(negedge clk);
        total_cnt++; if (err_n - e0 == 1) pass_cnt++; else $display("FAIL framing rx_error: got %0d pulses need 1", err_n - e0);
        total_cnt++; if (rx_log_n == n0) pass_cnt++; else $display("FAIL framing rx_latch: got %0d pulses need 0", rx_log_n - n0);
        total_cnt++; if (rx_data === 8'hFF) pass_cnt++; else $display("FAIL framing rx_data held: got %h need ff", rx_data);
        t0 = cyc;
        drive_rx(8'h81, 1'b1, 174);
        repeat (10) @(negedge clk);
        total_cnt++; if (rx_log_n - n0 == 1) pass_cnt++; else $display("FAIL recover latch count: got %0d need 1", rx_log_n - n0);
        total_cnt++; if (rx_data === 8'h81) pass_cnt++; else $display("FAIL recover rx_data: got %h need 81", rx_data);
        total_cnt++; if (err_n - e0 == 1) pass_cnt++; else $display("FAIL recover rx_error: got %0d pulses need 1", err_n - e0);
        lat = last_latch_cyc - t0;
        total_cnt++; if (lat >= 1655 && lat <= 1657) pass_cnt++; else $display("FAIL rx latency: got %0d cycles need 1656+-1", lat);
    endtask

    task automatic test_glitch();
        int n0;
        int e0;
        n0 = rx_log_n;
        e0 = err_n;
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * 174) @(negedge clk);
        total_cnt++; if (rx_log_n == n0) pass_cnt++; else $display("FAIL glitch rx_latch: got %0d pulses need 0", rx_log_n - n0);
        total_cnt++; if (err_n == e0) pass_cnt++; else $display("FAIL glitch rx_error: got %0d pulses need 0", err_n - e0);
        total_cnt++; if (rx_data === 8'h81) pass_cnt++; else $display("FAIL glitch rx_data: got %h need 81", rx_data);
    endtask

    task automatic test_min_div();
        int n0;
        n0 = rx_log_n;
        baud_div = 16'd0;
        loop_en  = 1'b1;
        tx_frame_check(8'h5A, 2, 1'b0, "div0");
        repeat (10) @(negedge clk);
        loop_en = 1'b0;
        total_cnt++; if (rx_log_n - n0 == 1) pass_cnt++; else $display("FAIL div0 latch count: got %0d need 1", rx_log_n - n0);
        total_cnt++; if (rx_data === 8'h5A) pass_cnt++; else $display("FAIL div0 rx_data: got %h need 5a", rx_data);
        baud_div = 16'd174;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tx_a5();
        test_ignored_strobe();
        test_back_to_back();
        test_framing_error();
        test_glitch();
        test_min_div();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ice_uart.md
# ice_uart

Byte-oriented full-duplex UART with a runtime-programmable baud divisor. It carries the host serial link into the ICE top level: the receiver deserialises the USB-bridge line into bytes for the command parser, and the transmitter serialises response bytes back to the host. The same block also serves as a host-side line driver in system benches. Frame format is fixed at 8N1, LSB first, idle-high line.

## Interface
- No parameters; all configuration is through ports.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- baud_div  input  16  clk cycles per bit period (174 = 115200 baud at 20 MHz). Must be held stable while not idle.
- rx_in  input  1  serial receive line, asynchronous, idle high.
- tx_out  output  1  serial transmit line, idle high.
- tx_latch  input  1  one-cycle strobe; loads tx_data and starts a frame.
- tx_data  input  8  byte to transmit; sampled only on the accepting edge.
- tx_empty  output  1  high when the transmitter is idle and able to accept a byte.
- rx_data  output  8  last correctly received byte; holds until the next good frame.
- rx_latch  output  1  one-cycle pulse when rx_data is updated.
- rx_error  output  1  one-cycle pulse on framing error (stop bit sampled low).

## Operation
- Reset values:
  - tx_out=1, tx_empty=1.
  - rx_data=0x00, rx_latch=0, rx_error=0.
  - Both state machines return to IDLE and all counters clear.
  - Reset asserted mid-frame aborts the frame immediately; no partial byte or pulse is emitted.
- Effective divisor: baud_div values 0 and 1 are treated as 2.
- Transmitter states: IDLE, START, DATA(0..7), STOP.
  - IDLE to START: on a clock edge with tx_latch=1 and tx_empty=1. At that edge tx_data is captured into a shift register, tx_empty goes 0 and tx_out goes 0.
  - tx_latch while tx_empty=0 is ignored; the captured byte is unaffected.
  - Each state holds tx_out for exactly baud_div cycles.
  - DATA sends bit 0 first. STOP drives 1.
  - At the end of STOP, tx_empty returns to 1 and the machine goes to IDLE.
  - A tx_latch on the same edge that tx_empty rises is not accepted. It is accepted from the following edge onward.
- Receiver states: IDLE, START, DATA(0..7), STOP.
  - rx_in passes through a 2-flop synchroniser; all logic uses the synchronised value.
  - IDLE to START: on a synchronised high-to-low transition. After a framing error the line must be seen high before a new start is armed.
  - START: wait floor(baud_div/2) cycles, then resample. If high, treat as a glitch and return to IDLE with no outputs. If low, proceed.
  - DATA: sample every baud_div cycles, shifting LSB first.
  - STOP: sample once after baud_div cycles.
    - If 1: load rx_data and pulse rx_latch for 1 cycle.
    - If 0: pulse rx_error for 1 cycle and leave rx_data unchanged.
  - Return to IDLE in the cycle after the pulse.
- TX and RX are fully independent; simultaneous activity on both is required to work.

## Timing
- TX latency: tx_out falls on the accepting edge.
- Bit boundaries fall at accept + k·baud_div cycles, k=1..9.
- tx_empty rises exactly 10·baud_div cycles after the accepting edge. For baud_div=174 that is 1740 cycles.
- Back-to-back TX throughput: one byte per 10·baud_div+1 cycles. The 1-cycle gap comes from the strobe being accepted no earlier than the edge after tx_empty rises.
- RX sample points: 2-cycle synchroniser delay, then mid-bit. rx_latch asserts about 9.5·baud_div + 3 cycles after the start-bit falling edge on rx_in. Tolerance is ±1 cycle.
- Receiver tolerates ±3% baud mismatch.

## Test plan
- Reset: assert reset mid-TX-frame (after 3 bit periods). Expect tx_out=1 and tx_empty=1 immediately, with no glitch after release.
- TX byte 0xA5, baud_div=174:
  - tx_out sequence 0,1,0,1,0,0,1,0,1,1, each level held 174 cycles.
  - tx_empty low for exactly 1740 cycles.
- TX ignored strobe: pulse tx_latch with 0x00 while sending 0xFF. Expect the frame to remain 0xFF and no second frame to follow.
- Loopback of tx_out to rx_in, streaming 0x00, 0x55 and 0xFF with the bench waiting on the tx_empty rising edge between strobes:
  - Expect three rx_latch pulses with matching rx_data.
  - Expect no rx_error.
- RX framing error: drive a frame of 0x3C with the stop bit low. Expect:
  - an rx_error pulse;
  - rx_data unchanged and no rx_latch;
  - the next valid frame, 0x81, received correctly after the line returns high.
- RX glitch: drive a low pulse on rx_in of 20 cycles with baud_div=174. Expect no rx_latch and no rx_error.
